// File: rtl/ahb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ahb_arbiter_pkg : shared htrans encodings and the round-robin pick helper. |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package ahb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    localparam int unsigned c_max_masters = 16;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } rr_pick_t;

    // The search starts just after ptr, so the last winner is considered last.
    function automatic rr_pick_t rr_pick(input logic [15:0] req, input logic [3:0] ptr,
                                         input int unsigned n);
        rr_pick_t   r;
        logic [4:0] cand;
        r = '0;
        for (int unsigned k = 1; k <= c_max_masters; k++) begin
            cand = {1'b0, ptr} + 5'(k);
            if (cand >= 5'(n)) begin
                cand = cand - 5'(n);
            end
            if (k <= n && !r.valid && req[cand[3:0]]) begin
                r.valid = 1'b1;
                r.idx   = cand[3:0];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ahb_bus_arbiter_if : master-side request/bus lanes and the muxed slave bus. |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface ahb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32
);
    localparam int IDX_W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0]            hbusreq;
    logic [NUM_MASTERS-1:0]            hlock;
    logic                              hready;
    logic [2*NUM_MASTERS-1:0]          htrans_m;
    logic [ADDR_WIDTH*NUM_MASTERS-1:0] haddr_m;
    logic [NUM_MASTERS-1:0]            hwrite_m;
    logic [DATA_WIDTH*NUM_MASTERS-1:0] hwdata_m;

    logic [NUM_MASTERS-1:0]            hgrant;
    logic [IDX_W-1:0]                  hmaster;
    logic                              hmastlock;
    logic [1:0]                        htrans;
    logic [ADDR_WIDTH-1:0]             haddr;
    logic                              hwrite;
    logic [DATA_WIDTH-1:0]             hwdata;

    modport arbiter (
        input  hbusreq, hlock, hready, htrans_m, haddr_m, hwrite_m, hwdata_m,
        output hgrant, hmaster, hmastlock, htrans, haddr, hwrite, hwdata
    );

    modport master (
        output hbusreq, hlock, htrans_m, haddr_m, hwrite_m, hwdata_m,
        input  hgrant, hmaster, hready
    );

    modport slave (
        input  htrans, haddr, hwrite, hwdata, hmaster, hmastlock,
        output hready
    );

endinterface
`default_nettype wire

// File: rtl/ahb_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ahb_rr_picker : combinational round-robin selection with wrap-around.     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module ahb_rr_picker
    import ahb_arbiter_pkg::*;
#(
    parameter  int NUM_MASTERS = 4,
    localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  wire logic [NUM_MASTERS-1:0] req,
    input  wire logic [IDX_W-1:0]       ptr,
    output logic      [IDX_W-1:0]       idx,
    output logic                        valid
);

    logic [15:0] w_req;
    logic [3:0]  w_ptr;
    rr_pick_t    w_pick;
    logic        unused_idx_hi;

    always_comb begin
        w_req                    = '0;
        w_req[NUM_MASTERS-1:0]   = req;
        w_ptr                    = '0;
        w_ptr[IDX_W-1:0]         = ptr;
        w_pick                   = rr_pick(w_req, w_ptr, NUM_MASTERS);
    end

    assign idx           = w_pick.idx[IDX_W-1:0];
    assign valid         = w_pick.valid;
    assign unused_idx_hi = ^w_pick.idx;

endmodule
`default_nettype wire

// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ahb_bus_arbiter : round-robin AHB-lite arbiter with lock hold and bus mux. |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module ahb_bus_arbiter
    import ahb_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int DEFAULT_MASTER = 0
) (
    input wire logic hclk,
    input wire logic hresetn,
    ahb_bus_arbiter_if.arbiter bus
);

    localparam int               IDX_W         = $clog2(NUM_MASTERS);
    localparam logic [IDX_W-1:0] c_default_idx = IDX_W'(DEFAULT_MASTER);

    logic [IDX_W-1:0]       r_grant_idx, r_hmaster, r_dp_master, r_ptr;
    logic                   r_hmastlock;
    logic [IDX_W-1:0]       w_pick_idx, w_next_grant, w_next_ptr;
    logic                   w_pick_valid, w_lock_hold;
    logic [NUM_MASTERS-1:0] w_hgrant;
    logic [1:0]             w_htrans;
    logic [ADDR_WIDTH-1:0]  w_haddr;
    logic                   w_hwrite;
    logic [DATA_WIDTH-1:0]  w_hwdata;

    ahb_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
        .req   (bus.hbusreq),
        .ptr   (r_ptr),
        .idx   (w_pick_idx),
        .valid (w_pick_valid)
    );

    // Lock only sustains an existing grant; it never attracts one.
    assign w_lock_hold = bus.hlock[r_grant_idx] && bus.hbusreq[r_grant_idx];

    always_comb begin
        w_next_grant = c_default_idx;
        w_next_ptr   = r_ptr;
        if (w_lock_hold) begin
            w_next_grant = r_grant_idx;
        end else if (w_pick_valid) begin
            w_next_grant = w_pick_idx;
            w_next_ptr   = w_pick_idx;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_grant_idx <= c_default_idx;
            r_hmaster   <= c_default_idx;
            r_dp_master <= c_default_idx;
            r_hmastlock <= 1'b0;
            r_ptr       <= c_default_idx;
        end else if (bus.hready) begin
            r_dp_master <= r_hmaster;
            r_hmaster   <= r_grant_idx;
            r_hmastlock <= bus.hlock[r_grant_idx];
            r_grant_idx <= w_next_grant;
            r_ptr       <= w_next_ptr;
        end
    end

    always_comb begin
        w_hgrant              = '0;
        w_hgrant[r_grant_idx] = 1'b1;
        w_htrans              = IDLE;
        w_haddr               = '0;
        w_hwrite              = 1'b0;
        w_hwdata              = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_hmaster == IDX_W'(i)) begin
                w_htrans = bus.htrans_m[2*i +: 2];
                w_haddr  = bus.haddr_m[ADDR_WIDTH*i +: ADDR_WIDTH];
                w_hwrite = bus.hwrite_m[i];
            end
            if (r_dp_master == IDX_W'(i)) begin
                w_hwdata = bus.hwdata_m[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    assign bus.hgrant    = w_hgrant;
    assign bus.hmaster   = r_hmaster;
    assign bus.hmastlock = r_hmastlock;
    assign bus.htrans    = w_htrans;
    assign bus.haddr     = w_haddr;
    assign bus.hwrite    = w_hwrite;
    assign bus.hwdata    = w_hwdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ahb_bus_arbiter : vector table, corner sequences and random model check.|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_ahb_bus_arbiter;
    import ahb_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int DEF = 0;

    logic hclk    = 1'b0;
    logic hresetn = 1'b0;

    ahb_bus_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ahb_bus_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEFAULT_MASTER(DEF)
    ) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    always #5 hclk = ~hclk;

    int total = 0;
    int bad   = 0;

    logic [1:0]    tr [N];
    logic [AW-1:0] ad [N];
    logic          wr [N];
    logic [DW-1:0] wd [N];

    // Reference state: who is granted, who owns address and data phases.
    int m_g, m_hm, m_dp, m_ptr;
    logic m_lk;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] lock;
        logic         rdy;
        int           g;
        int           hm;
        int           dp;
        logic         lk;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_masters();
        for (int i = 0; i < N; i++) begin
            bus.htrans_m[2*i +: 2]   = tr[i];
            bus.haddr_m[AW*i +: AW]  = ad[i];
            bus.hwrite_m[i]          = wr[i];
            bus.hwdata_m[DW*i +: DW] = wd[i];
        end
    endtask

    task automatic model_reset();
        m_g = DEF; m_hm = DEF; m_dp = DEF; m_ptr = DEF; m_lk = 1'b0;
    endtask

    task automatic model_edge();
        int ng;
        int np;
        bit found;
        if (!hresetn) begin
            model_reset();
            return;
        end
        if (!bus.hready) return;
        ng = DEF; np = m_ptr; found = 0;
        if (bus.hlock[IW'(m_g)] && bus.hbusreq[IW'(m_g)]) begin
            ng = m_g;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!found && bus.hbusreq[IW'(c)]) begin
                    found = 1; ng = c; np = c;
                end
            end
        end
        m_lk  = bus.hlock[IW'(m_g)];
        m_dp  = m_hm;
        m_hm  = m_g;
        m_g   = ng;
        m_ptr = np;
    endtask

    task automatic tick();
        @(posedge hclk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] eg;
        eg = '0;
        eg[IW'(m_g)] = 1'b1;
        check({tag, " hgrant"},    64'(bus.hgrant),    64'(eg));
        check({tag, " hmaster"},   64'(bus.hmaster),   64'(m_hm));
        check({tag, " hmastlock"}, 64'(bus.hmastlock), 64'(m_lk));
        check({tag, " htrans"},    64'(bus.htrans),    64'(tr[IW'(m_hm)]));
        check({tag, " haddr"},     64'(bus.haddr),     64'(ad[IW'(m_hm)]));
        check({tag, " hwrite"},    64'(bus.hwrite),    64'(wr[IW'(m_hm)]));
        check({tag, " hwdata"},    64'(bus.hwdata),    64'(wd[IW'(m_dp)]));
    endtask

    task automatic clear_masters();
        for (int i = 0; i < N; i++) begin
            tr[i] = IDLE; ad[i] = AW'(8'h10 + i); wr[i] = 1'b0; wd[i] = DW'(32'hA000_0000 + i);
        end
        drive_masters();
    endtask

    task automatic reset_dut();
        hresetn     = 1'b0;
        bus.hready  = 1'b1;
        bus.hbusreq = '0;
        bus.hlock   = '0;
        clear_masters();
        @(negedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;
        model_reset();
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 4'b0000, 1'b1, 1, 0, 0, 1'b0};
        tbl[1]  = '{4'b1111, 4'b0000, 1'b1, 2, 1, 0, 1'b0};
        tbl[2]  = '{4'b1111, 4'b0000, 1'b1, 3, 2, 1, 1'b0};
        tbl[3]  = '{4'b1111, 4'b0000, 1'b1, 0, 3, 2, 1'b0};
        tbl[4]  = '{4'b1111, 4'b0000, 1'b1, 1, 0, 3, 1'b0};
        tbl[5]  = '{4'b0000, 4'b0000, 1'b1, 0, 1, 0, 1'b0};
        tbl[6]  = '{4'b0100, 4'b0100, 1'b1, 2, 0, 1, 1'b0};
        tbl[7]  = '{4'b1100, 4'b0100, 1'b1, 2, 2, 0, 1'b1};
        tbl[8]  = '{4'b1100, 4'b0100, 1'b1, 2, 2, 2, 1'b1};
        tbl[9]  = '{4'b1100, 4'b0100, 1'b0, 2, 2, 2, 1'b1};
        tbl[10] = '{4'b1100, 4'b0000, 1'b1, 3, 2, 2, 1'b0};
        tbl[11] = '{4'b1100, 4'b0000, 1'b1, 2, 3, 2, 1'b0};
        tbl[12] = '{4'b0011, 4'b0000, 1'b0, 2, 3, 2, 1'b0};
        tbl[13] = '{4'b0011, 4'b0000, 1'b1, 0, 2, 3, 1'b0};
        tbl[14] = '{4'b0011, 4'b0000, 1'b1, 1, 0, 2, 1'b0};

        // Reset parking with requests pending during reset.
        hresetn     = 1'b0;
        bus.hready  = 1'b1;
        bus.hlock   = '0;
        bus.hbusreq = 4'b0110;
        clear_masters();
        repeat (2) @(posedge hclk);
        #1;
        check("park hgrant",    64'(bus.hgrant),    64'(4'b0001));
        check("park hmaster",   64'(bus.hmaster),   64'(0));
        check("park hmastlock", 64'(bus.hmastlock), 64'(0));
        @(negedge hclk);
        hresetn = 1'b1;
        model_reset();
        tick();
        check("park first grant", 64'(bus.hgrant), 64'(4'b0010));
        tick();
        check("park first hmaster", 64'(bus.hmaster), 64'(1));

        // Hand-derived vector table: rotation, parking, lock, stalls.
        reset_dut();
        for (int i = 0; i < 15; i++) begin
            logic [N-1:0] eg;
            bus.hbusreq = tbl[i].req;
            bus.hlock   = tbl[i].lock;
            bus.hready  = tbl[i].rdy;
            tick();
            eg = '0;
            eg[IW'(tbl[i].g)] = 1'b1;
            check($sformatf("vec%0d hgrant", i),    64'(bus.hgrant),    64'(eg));
            check($sformatf("vec%0d hmaster", i),   64'(bus.hmaster),   64'(tbl[i].hm));
            check($sformatf("vec%0d dp hwdata", i), 64'(bus.hwdata),    64'(wd[IW'(tbl[i].dp)]));
            check($sformatf("vec%0d hmastlock", i), 64'(bus.hmastlock), 64'(tbl[i].lk));
        end

        // Stall: master 1 in data phase, master 2 in address phase.
        reset_dut();
        wd[1] = 32'hDEAD_BEEF;
        drive_masters();
        bus.hbusreq = 4'b1111;
        repeat (3) tick();
        bus.hready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("stall hgrant",  64'(bus.hgrant),  64'(4'b1000));
            check("stall hmaster", 64'(bus.hmaster), 64'(2));
            check("stall hwdata",  64'(bus.hwdata),  64'(32'hDEAD_BEEF));
            check_model("stall");
        end
        bus.hready = 1'b1;
        tick();
        check_model("stall release");

        // Mux: master 3 alone on the bus.
        reset_dut();
        tr[3] = NONSEQ; ad[3] = 8'hA5; wr[3] = 1'b1; wd[3] = 32'h1234_5678;
        drive_masters();
        bus.hbusreq = 4'b1000;
        tick();
        check("mux hgrant", 64'(bus.hgrant), 64'(4'b1000));
        tick();
        check("mux haddr",  64'(bus.haddr),  64'(8'hA5));
        check("mux hwrite", 64'(bus.hwrite), 64'(1));
        check("mux htrans", 64'(bus.htrans), 64'(2'b10));
        tick();
        check("mux hwdata", 64'(bus.hwdata), 64'(32'h1234_5678));
        check_model("mux");

        // Asynchronous reset while master 2 holds a locked transfer.
        reset_dut();
        bus.hbusreq = 4'b0100;
        bus.hlock   = 4'b0100;
        tick();
        tick();
        check("lock hmastlock", 64'(bus.hmastlock), 64'(1));
        check("lock hgrant",    64'(bus.hgrant),    64'(4'b0100));
        #2;
        hresetn = 1'b0;
        #1;
        check("async hgrant",    64'(bus.hgrant),    64'(4'b0001));
        check("async hmaster",   64'(bus.hmaster),   64'(0));
        check("async hmastlock", 64'(bus.hmastlock), 64'(0));
        model_reset();
        @(negedge hclk);
        hresetn = 1'b1;

        // Randomised traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            bus.hready  = ($urandom_range(0, 4) != 0);
            bus.hbusreq = 4'($urandom);
            bus.hlock   = 4'($urandom) & 4'($urandom);
            for (int i = 0; i < N; i++) begin
                tr[i] = 2'($urandom);
                ad[i] = 8'($urandom);
                wr[i] = 1'($urandom);
                wd[i] = $urandom;
            end
            drive_masters();
            tick();
            check_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
